// File: rtl/narrow_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : narrow_bus_arbiter_if
// Purpose  : Requester handshakes and 8-bit pin bus of narrow_bus_arbiter.
// Revision : 1.0
// ============================================================================
interface narrow_bus_arbiter_if;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        ack0;
  logic [31:0] rdata0;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        ack1;
  logic [31:0] rdata1;

  logic [7:0]  bus_out;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_oe;
  logic        busy;
  logic        grant_id;

  // Requesters plus the pad side of the pins.
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_data_in,
    input  ack0, rdata0, ack1, rdata1, bus_out, bus_data_out, bus_oe, busy, grant_id
  );

  // The arbiter itself.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_data_in,
    output ack0, rdata0, ack1, rdata1, bus_out, bus_data_out, bus_oe, busy, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/narrow_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : narrow_bus_arbiter
// Purpose  : Arbitrates two 32-bit requesters and byte-serialises one transaction
//            at a time on the 8-bit pin bus. Define NBA_FIXED_PRIO_EN for fixed
//            priority (requester 0 always wins); default is round-robin.
// Revision : 1.0
// ============================================================================
module narrow_bus_arbiter #(
  parameter int TURN_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  narrow_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_CMD  = 3'd2,
    ST_TURN = 3'd3,
    ST_READ = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0] TURN_LAST = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  next_idx;
  logic [1:0]  turn_cnt;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [23:0] shadow;

  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

`ifndef NBA_FIXED_PRIO_EN
  logic        last_grant;
`endif

  assign next_idx = idx + 2'd1;

  always_comb begin
`ifdef NBA_FIXED_PRIO_EN
    win = ~bus.req0;
`else
    win = (bus.req0 && bus.req1) ? ~last_grant : ~bus.req0;
`endif
    sel_we    = win ? bus.we1    : bus.we0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      idx              <= 2'd0;
      turn_cnt         <= 2'd0;
      cur_we           <= 1'b0;
      cur_addr         <= 32'h0;
      cur_wdata        <= 32'h0;
      shadow           <= 24'h0;
`ifndef NBA_FIXED_PRIO_EN
      last_grant       <= 1'b1;
`endif
      bus.ack0         <= 1'b0;
      bus.ack1         <= 1'b0;
      bus.rdata0       <= 32'h0;
      bus.rdata1       <= 32'h0;
      bus.bus_out      <= 8'h00;
      bus.bus_data_out <= 8'h00;
      bus.bus_oe       <= 8'h00;
      bus.busy         <= 1'b0;
      bus.grant_id     <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req0 || bus.req1) begin
            state            <= ST_ADDR;
            idx              <= 2'd0;
            cur_we           <= sel_we;
            cur_addr         <= sel_addr;
            cur_wdata        <= sel_wdata;
            bus.grant_id     <= win;
            bus.busy         <= 1'b1;
`ifndef NBA_FIXED_PRIO_EN
            last_grant       <= win;
`endif
            bus.bus_out      <= sel_addr[7:0];
            bus.bus_data_out <= sel_we ? sel_wdata[7:0] : 8'h00;
            bus.bus_oe       <= {8{sel_we}};
          end
        end

        ST_ADDR: begin
          if (idx == 2'd3) begin
            state            <= ST_CMD;
            bus.bus_out      <= {6'b0, bus.grant_id, cur_we};
            bus.bus_data_out <= 8'h00;
            bus.bus_oe       <= 8'h00;
          end else begin
            idx              <= next_idx;
            bus.bus_out      <= cur_addr[{next_idx, 3'b000} +: 8];
            bus.bus_data_out <= cur_we ? cur_wdata[{next_idx, 3'b000} +: 8] : 8'h00;
          end
        end

        ST_CMD: begin
          bus.bus_out <= 8'h00;
          if (cur_we) begin
            state <= ST_DONE;
            if (bus.grant_id) bus.ack1 <= 1'b1;
            else              bus.ack0 <= 1'b1;
          end else if (TURN_CYCLES == 0) begin
            state <= ST_READ;
            idx   <= 2'd0;
          end else begin
            state    <= ST_TURN;
            turn_cnt <= 2'd0;
          end
        end

        ST_TURN: begin
          if (turn_cnt == TURN_LAST) begin
            state <= ST_READ;
            idx   <= 2'd0;
          end else begin
            turn_cnt <= turn_cnt + 2'd1;
          end
        end

        ST_READ: begin
          // LSB-first shift: after three bytes the shadow holds {b2, b1, b0}.
          shadow <= {bus.bus_data_in, shadow[23:8]};
          if (idx == 2'd3) begin
            state <= ST_DONE;
            if (bus.grant_id) begin
              bus.ack1   <= 1'b1;
              bus.rdata1 <= {bus.bus_data_in, shadow};
            end else begin
              bus.ack0   <= 1'b1;
              bus.rdata0 <= {bus.bus_data_in, shadow};
            end
          end else begin
            idx <= next_idx;
          end
        end

        ST_DONE: begin
          state        <= ST_IDLE;
          bus.busy     <= 1'b0;
          bus.grant_id <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_narrow_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_narrow_bus_arbiter
// Purpose  : Self-checking bench: directed vector table, corner sequences and a
//            randomized run against a transaction-schedule reference model.
// Revision : 1.0
// ============================================================================
module tb_narrow_bus_arbiter;
  localparam int T1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  narrow_bus_arbiter_if ifc ();
  narrow_bus_arbiter_if ifz ();

  narrow_bus_arbiter #(.TURN_CYCLES(T1)) dut   (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  narrow_bus_arbiter #(.TURN_CYCLES(0))  dut_z (.clk(clk), .rst_n(rst_n), .bus(ifz.slave));

  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbytes;
    logic [7:0]  exp_cmd;
    logic [31:0] exp_rdata;
    int          exp_ack;
  } vec_t;

  typedef struct {
    logic [7:0] bo;
    logic [7:0] bdo;
    logic [7:0] oe;
    logic       a0;
    logic       a1;
    logic       gid;
    int         rd;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  bit          rand_on;
  exp_t        sched[$];
  logic        m_last;
  logic [31:0] m_rd[2];
  logic [31:0] m_shadow;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_req(input int id, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      ifc.req0 = r; ifc.we0 = we; ifc.addr0 = a; ifc.wdata0 = d;
    end else begin
      ifc.req1 = r; ifc.we1 = we; ifc.addr1 = a; ifc.wdata1 = d;
    end
  endtask

  function automatic logic ack_of(input int id);
    return (id == 0) ? ifc.ack0 : ifc.ack1;
  endfunction

  function automatic logic [31:0] rdata_of(input int id);
    return (id == 0) ? ifc.rdata0 : ifc.rdata1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction on the T1 instance, edge k = k-th rising edge after the grant.
  task automatic run_txn(input vec_t v, input bit hold);
    int ae;
    int id;
    ae = -1;
    id = int'(v.who);
    @(negedge clk);
    chk("idle_before_grant", 32'(ifc.busy), 32'h0);
    set_req(id, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("addr_byte", 32'(ifc.bus_out), 32'(v.addr[8*k +: 8]));
        chk("wdata_byte", 32'(ifc.bus_data_out), v.we ? 32'(v.wdata[8*k +: 8]) : 32'h0);
        chk("oe_addr", 32'(ifc.bus_oe), v.we ? 32'hFF : 32'h0);
      end else if (k == 4) begin
        chk("cmd_byte", 32'(ifc.bus_out), 32'(v.exp_cmd));
        chk("oe_cmd", 32'(ifc.bus_oe), 32'h0);
      end
      if (k == 0) chk("grant_id", 32'(ifc.grant_id), 32'(v.who));
      if (!v.we && k >= 5 + T1 && k < 9 + T1) ifc.bus_data_in = v.rbytes[8*(k-5-T1) +: 8];
      else                                     ifc.bus_data_in = 8'($urandom);
      if (ack_of(id)) begin
        ae = k;
        chk("other_ack", 32'(ack_of(1 - id)), 32'h0);
        if (!hold) set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
        break;
      end
    end
    chk("ack_edge", 32'(ae), 32'(v.exp_ack));
  endtask

  function automatic void push_txn(logic w, logic we, logic [31:0] a, logic [31:0] d);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e = '{bo: a[8*k +: 8], bdo: (we ? d[8*k +: 8] : 8'h00), oe: {8{we}},
            a0: 1'b0, a1: 1'b0, gid: w, rd: -1};
      sched.push_back(e);
    end
    e = '{bo: {6'b0, w, we}, bdo: 8'h00, oe: 8'h00, a0: 1'b0, a1: 1'b0, gid: w, rd: -1};
    sched.push_back(e);
    if (!we) begin
      for (int t = 0; t < T1; t++) begin
        e = '{bo: 8'h00, bdo: 8'h00, oe: 8'h00, a0: 1'b0, a1: 1'b0, gid: w, rd: -1};
        sched.push_back(e);
      end
      for (int j = 0; j < 4; j++) begin
        e = '{bo: 8'h00, bdo: 8'h00, oe: 8'h00, a0: 1'b0, a1: 1'b0, gid: w, rd: j};
        sched.push_back(e);
      end
    end
    e = '{bo: 8'h00, bdo: 8'h00, oe: 8'h00, a0: ~w, a1: w, gid: w, rd: -1};
    sched.push_back(e);
  endfunction

  // Reference: each cycle after a grant is a queued schedule entry; empty queue means IDLE.
  task automatic model_run();
    exp_t e;
    logic w;
    while (rand_on) begin
      @(posedge clk);
      if (sched.size() > 0) begin
        e = sched.pop_front();
        if (e.rd >= 0) m_shadow[8*e.rd +: 8] = ifc.bus_data_in;
        if (e.rd == 3) m_rd[e.gid] = m_shadow;
      end else if (ifc.req0 || ifc.req1) begin
`ifdef NBA_FIXED_PRIO_EN
        w = ~ifc.req0;
`else
        if (ifc.req0 && ifc.req1) w = ~m_last;
        else                      w = ifc.req1;
        m_last = w;
`endif
        if (w) push_txn(w, ifc.we1, ifc.addr1, ifc.wdata1);
        else   push_txn(w, ifc.we0, ifc.addr0, ifc.wdata0);
      end
    end
  endtask

  task automatic check_run();
    logic [31:0] act;
    logic [31:0] exp;
    while (rand_on) begin
      @(negedge clk);
      if (!rand_on) break;
      act = {4'b0, ifc.busy, ifc.bus_out, ifc.bus_data_out, ifc.bus_oe,
             ifc.ack0, ifc.ack1, ifc.grant_id};
      if (sched.size() > 0)
        exp = {4'b0, 1'b1, sched[0].bo, sched[0].bdo, sched[0].oe,
               sched[0].a0, sched[0].a1, sched[0].gid};
      else
        exp = 32'h0;
      chk("rand_pins", act, exp);
      chk("rand_rdata0", ifc.rdata0, m_rd[0]);
      chk("rand_rdata1", ifc.rdata1, m_rd[1]);
    end
  endtask

  task automatic rand_requester(input int id);
    bit active;
    int waitc;
    active = 1'b0;
    waitc  = 0;
    while (rand_on) begin
      @(negedge clk);
      if (!rand_on) break;
      if (active) begin
        if (ack_of(id)) begin
          set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
          active = 1'b0;
        end else if (++waitc > 40) begin
          total++;
          bad++;
          $display("FAIL rand_ack_timeout: requester %0d got no ack within 40 cycles", id);
          set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
          active = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        set_req(id, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        active = 1'b1;
        waitc  = 0;
      end
    end
    set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[4];
    logic [31:0] exp_rd[2];
    int          exp_order[4];
    int          who;
    int          zae;
    logic [31:0] zbytes;

    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    ifc.bus_data_in = 8'h00;
    ifz.req0 = 1'b0; ifz.we0 = 1'b0; ifz.addr0 = 32'h0; ifz.wdata0 = 32'h0;
    ifz.req1 = 1'b0; ifz.we1 = 1'b0; ifz.addr1 = 32'h0; ifz.wdata1 = 32'h0;
    ifz.bus_data_in = 8'h00;
    rand_on = 1'b0;

    do_reset();
    chk("rst_busy",     32'(ifc.busy),         32'h0);
    chk("rst_bus_out",  32'(ifc.bus_out),      32'h0);
    chk("rst_bus_dout", 32'(ifc.bus_data_out), 32'h0);
    chk("rst_oe",       32'(ifc.bus_oe),       32'h0);
    chk("rst_acks",     32'({ifc.ack0, ifc.ack1}), 32'h0);
    chk("rst_grant",    32'(ifc.grant_id),     32'h0);
    chk("rst_rdata0",   ifc.rdata0,            32'h0);
    chk("rst_rdata1",   ifc.rdata1,            32'h0);

    vt[0] = '{who: 1'b0, we: 1'b0, addr: 32'h12345678, wdata: 32'h0, rbytes: 32'hDEADBEEF,
              exp_cmd: 8'h00, exp_rdata: 32'hDEADBEEF, exp_ack: 10};
    vt[1] = '{who: 1'b1, we: 1'b1, addr: 32'h000000A0, wdata: 32'hCAFEF00D, rbytes: 32'h0,
              exp_cmd: 8'h03, exp_rdata: 32'h0, exp_ack: 5};
    vt[2] = '{who: 1'b1, we: 1'b0, addr: 32'h89ABCDEF, wdata: 32'h0, rbytes: 32'h01234567,
              exp_cmd: 8'h02, exp_rdata: 32'h01234567, exp_ack: 10};
    vt[3] = '{who: 1'b0, we: 1'b1, addr: 32'hFFFF0000, wdata: 32'h5A5AA5A5, rbytes: 32'h0,
              exp_cmd: 8'h01, exp_rdata: 32'h0, exp_ack: 5};
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;

    for (int i = 0; i < 4; i++) begin
      run_txn(vt[i], 1'b0);
      if (!vt[i].we) exp_rd[int'(vt[i].who)] = vt[i].exp_rdata;
      chk("rdata0_after_txn", ifc.rdata0, exp_rd[0]);
      chk("rdata1_after_txn", ifc.rdata1, exp_rd[1]);
    end

    // Request held past ack: a fresh identical transaction after one IDLE cycle.
    vt[0].rbytes    = 32'h600DF00D;
    vt[0].exp_rdata = 32'h600DF00D;
    run_txn(vt[0], 1'b1);
    run_txn(vt[0], 1'b0);
    chk("held_rdata0", ifc.rdata0, 32'h600DF00D);

    // Asynchronous reset in READ2 of a read.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h12345678, 32'h0);
    repeat (9) @(negedge clk);
    chk("read2_busy", 32'(ifc.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy",    32'(ifc.busy),    32'h0);
    chk("midrst_oe",      32'(ifc.bus_oe),  32'h0);
    chk("midrst_bus_out", 32'(ifc.bus_out), 32'h0);
    chk("midrst_ack0",    32'(ifc.ack0),    32'h0);
    chk("midrst_rdata0",  ifc.rdata0,       32'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie from reset, each requester re-asserting right after its ack.
`ifdef NBA_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h00000100, 32'h11111111);
    set_req(1, 1'b1, 1'b1, 32'h00000200, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      who = -1;
      for (int c = 0; c < 40 && who < 0; c++) begin
        @(negedge clk);
        if (ifc.ack0)      who = 0;
        else if (ifc.ack1) who = 1;
      end
      chk("tie_order", 32'(who), 32'(exp_order[i]));
      if (who >= 0) begin
        set_req(who, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        if (who == 0) set_req(0, 1'b1, 1'b1, 32'h00000100, 32'h11111111);
        else          set_req(1, 1'b1, 1'b1, 32'h00000200, 32'h22222222);
      end
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    do_reset();

    // Zero-turnaround read: READ0 directly after CMD.
    zbytes = 32'h44332211;
    zae    = -1;
    @(negedge clk);
    ifz.req0 = 1'b1; ifz.we0 = 1'b0; ifz.addr0 = 32'h0BADF00D;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 4) chk("z_cmd", 32'(ifz.bus_out), 32'h0);
      if (k >= 5 && k < 9) ifz.bus_data_in = zbytes[8*(k-5) +: 8];
      else                 ifz.bus_data_in = 8'($urandom);
      if (ifz.ack0) begin
        zae = k;
        ifz.req0 = 1'b0;
        break;
      end
    end
    chk("z_ack_edge", 32'(zae), 32'd9);
    chk("z_rdata0", ifz.rdata0, 32'h44332211);

    // Randomized traffic against the schedule model.
    do_reset();
    sched.delete();
    m_last   = 1'b1;
    m_rd[0]  = 32'h0;
    m_rd[1]  = 32'h0;
    m_shadow = 32'h0;
    rand_on  = 1'b1;
    fork
      begin
        repeat (3000) @(negedge clk);
        rand_on = 1'b0;
      end
      rand_requester(0);
      rand_requester(1);
      model_run();
      check_run();
      begin
        while (rand_on) begin
          @(negedge clk);
          ifc.bus_data_in = 8'($urandom);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
